// File: rtl/memblock_pkg.sv
// Shared types and sizes for the memory-block operand reader.
// Holds the address/count widths, the bank depth and the reader FSM state type.
package memblock_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/memblock_reader_if.sv
// Bus bundle between the operand reader, the A/B memory banks and the consumer.
// slave  : the reader (takes start/base/count, read data and op_ready;
//          drives mem_addr, operands, op_valid, busy, done)
// master : the environment driving the reader (requester, banks, consumer)
interface memblock_reader_if #(
    parameter int unsigned N = 8
);
    import memblock_pkg::*;

    localparam int unsigned DW = N + 1;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     a_rd;
    logic [DW-1:0]     b_rd;
    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
    logic              op_valid;
    logic              op_ready;
    logic              busy;
    logic              done;

    modport slave (
        input  start, base_addr, count, a_rd, b_rd, op_ready,
        output mem_addr, op_a, op_b, op_valid, busy, done
    );

    modport master (
        output start, base_addr, count, a_rd, b_rd, op_ready,
        input  mem_addr, op_a, op_b, op_valid, busy, done
    );

endinterface

// File: rtl/memblock_addr_seq.sv
// Address register and remaining-pair counter for a read burst.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : latch base_i into the address and count_i (saturated) into the counter
//   step_i     : advance the address (wrapping at DEPTH) and decrement the counter
//   base_i     : burst start address
//   count_i    : requested pair count, values above DEPTH saturate to DEPTH
//   addr_o     : current address register
//   last_o     : exactly one pair remains
module memblock_addr_seq #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_i,
    input  logic                            step_i,
    input  logic [memblock_pkg::ADDR_W-1:0] base_i,
    input  logic [memblock_pkg::CNT_W-1:0]  count_i,
    output logic [memblock_pkg::ADDR_W-1:0] addr_o,
    output logic                            last_o
);
    import memblock_pkg::*;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;

    // Next address/count: load wins over step; both hold otherwise.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = base_i;
            rem_d  = (count_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count_i;
        end else if (step_i) begin
            addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
            rem_d  = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/memblock_reader.sv
// Reads Count A/B pairs from two lock-step memory banks starting at Base_Addr
// and presents each pair to a consumer with a valid/ready handshake.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of memblock_reader_if (start/base_addr/count request,
//              mem_addr + a_rd/b_rd bank access, op_a/op_b/op_valid/op_ready
//              consumer handshake, busy/done status)
// DEPTH must stay consistent with the 4-bit address (16 entries).
module memblock_reader #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = memblock_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    memblock_reader_if.slave bus
);
    import memblock_pkg::*;

    localparam int unsigned DW = N + 1;

    state_t            state_q, state_d;
    logic              load;
    logic              step;
    logic              capture;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     op_a_q, op_a_d;
    logic [DW-1:0]     op_b_q, op_b_d;
    logic              op_valid_q;
    logic              busy_q;
    logic              done_q;

    memblock_addr_seq #(
        .DEPTH (DEPTH)
    ) u_addr_seq (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .step_i  (step),
        .base_i  (bus.base_addr),
        .count_i (bus.count),
        .addr_o  (addr),
        .last_o  (last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and sequencer controls.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.op_ready) begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        step    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operands only change when a fresh bank read is captured.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (capture) begin
            op_a_d = bus.a_rd;
            op_b_d = bus.b_rd;
        end
    end

    // Status flags are the state decode, flopped alongside the state register
    // so they track it exactly without combinational output paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= (state_d == ST_HOLD);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // The address register only moves when entering ISSUE, so it holds otherwise.
    assign bus.mem_addr = addr;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_valid = op_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
